// File: rtl/dmem_responder_if.sv
// ============================================================================
// dmem_responder_if : CPU data-memory request/response bundle
// Revision: 1.0
// ============================================================================
`default_nettype none

interface dmem_responder_if;
  logic        req_i;
  logic        we_i;
  logic [31:0] addr_i;
  logic [31:0] wdata_i;
  logic        ready_o;
  logic        ack_o;
  logic [31:0] rdata_o;
  logic        err_o;
  logic        busy_o;

  modport master (
    output req_i, we_i, addr_i, wdata_i,
    input  ready_o, ack_o, rdata_o, err_o, busy_o
  );

  modport slave (
    input  req_i, we_i, addr_i, wdata_i,
    output ready_o, ack_o, rdata_o, err_o, busy_o
  );
endinterface

`default_nettype wire

// File: rtl/dmem_responder.sv
// ============================================================================
// dmem_responder : fixed-latency word memory answering CPU MEM-stage requests
// Optional macro DMEM_RESP_ERR_EN flags misaligned / out-of-range addresses.
// Revision: 1.0
// ============================================================================
`default_nettype none

module dmem_responder #(
  parameter int DEPTH_LOG2 = 7,
  parameter int LATENCY    = 3
) (
  input  wire logic        clk_i,
  input  wire logic        rst_i,
  dmem_responder_if.slave  bus
);

  localparam int         DEPTH    = 1 << DEPTH_LOG2;
  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  logic                    we_q, we_d;
  logic [DEPTH_LOG2-1:0]   idx_q, idx_d;
  logic [31:0]             wdata_q, wdata_d;
  logic                    err_q, err_d;
  logic [31:0]             mem_q [DEPTH];

  logic                    ready;
  logic                    commit;
  logic                    addr_bad;
  logic                    ack;

`ifdef DMEM_RESP_ERR_EN
  assign addr_bad = (bus.addr_i[1:0] != 2'b00) ||
                    (bus.addr_i[31:DEPTH_LOG2+2] != '0);
`else
  // Upper and byte-offset bits are don't-care; the index simply wraps.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.addr_i[31:DEPTH_LOG2+2], bus.addr_i[1:0]};
  assign addr_bad         = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    err_d   = err_q;
    ready   = 1'b0;
    commit  = 1'b0;

    case (state_q)
      IDLE: ready = 1'b1;
      WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = RESP;
          commit  = we_q && !err_q;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        ready   = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Acceptance overrides the RESP->IDLE move to give back-to-back service.
    if (ready && bus.req_i) begin
      state_d = WAIT;
      cnt_d   = CNT_LOAD;
      we_d    = bus.we_i;
      idx_d   = bus.addr_i[DEPTH_LOG2+1:2];
      wdata_d = bus.wdata_i;
      err_d   = addr_bad;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      idx_q   <= '0;
      wdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= 32'd0;
      end
    end else if (commit) begin
      mem_q[idx_q] <= wdata_q;
    end
  end

  assign ack         = (state_q == RESP);
  assign bus.ack_o   = ack;
  assign bus.busy_o  = (state_q == WAIT);
  assign bus.ready_o = ready && !rst_i;
  assign bus.err_o   = ack && err_q;
  assign bus.rdata_o = (ack && !we_q && !err_q) ? mem_q[idx_q] : 32'd0;

endmodule

`default_nettype wire

// File: tb/tb_dmem_responder.sv
// ============================================================================
// tb_dmem_responder : vector table, directed corner cases and random traffic
// checked against a transaction-level model. Honours DMEM_RESP_ERR_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_dmem_responder;

  localparam int LAT = 3;

  logic clk = 1'b0;
  logic rst;

  dmem_responder_if bus0 ();
  dmem_responder_if bus1 ();

  dmem_responder #(.DEPTH_LOG2(7), .LATENCY(LAT)) u_dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus0)
  );

  dmem_responder #(.DEPTH_LOG2(7), .LATENCY(1)) u_dut_l1 (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus1)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          req;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    bit          ready;
    bit          ack;
    logic [31:0] rdata;
    bit          err;
  } vec_t;

  vec_t tbl[$];

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  // Transaction model: one outstanding request that completes at ack_cyc.
  logic [31:0] mdl_mem [128];
  bit          pend;
  int          ack_cyc;
  bit          p_we;
  int          p_idx;
  logic [31:0] p_wd;
  bit          p_err;

  function automatic bit mdl_bad(input logic [31:0] a);
`ifdef DMEM_RESP_ERR_EN
    return (a[1:0] != 2'b00) || (a[31:9] != 23'd0);
`else
    return 1'b0;
`endif
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic add_vec(input bit req, input bit we, input logic [31:0] addr,
                         input logic [31:0] wd, input bit rdy, input bit ack,
                         input logic [31:0] rd, input bit err);
    vec_t v;
    v.req = req; v.we = we; v.addr = addr; v.wdata = wd;
    v.ready = rdy; v.ack = ack; v.rdata = rd; v.err = err;
    tbl.push_back(v);
  endtask

  // Called at posedge+1; drives one cycle, checks against the model at negedge.
  task automatic cycle(input bit req, input bit we, input logic [31:0] addr,
                       input logic [31:0] wd, output bit a_ready, output bit a_ack,
                       output logic [31:0] a_rdata, output bit a_err);
    bit          e_ready, e_ack, e_busy, e_err;
    logic [31:0] e_rdata;
    bus0.req_i   = req;
    bus0.we_i    = we;
    bus0.addr_i  = addr;
    bus0.wdata_i = wd;
    @(negedge clk);
    e_ready = !pend || (cyc == ack_cyc);
    e_ack   = pend && (cyc == ack_cyc);
    e_busy  = pend && (cyc < ack_cyc);
    if (e_ack && p_we && !p_err) mdl_mem[p_idx] = p_wd;
    e_rdata = (e_ack && !p_we && !p_err) ? mdl_mem[p_idx] : 32'd0;
    e_err   = e_ack && p_err;
    a_ready = bus0.ready_o;
    a_ack   = bus0.ack_o;
    a_rdata = bus0.rdata_o;
    a_err   = bus0.err_o;
    chk("mdl_ready", {31'd0, a_ready}, {31'd0, e_ready});
    chk("mdl_ack",   {31'd0, a_ack},   {31'd0, e_ack});
    chk("mdl_busy",  {31'd0, bus0.busy_o}, {31'd0, e_busy});
    chk("mdl_rdata", a_rdata, e_rdata);
    chk("mdl_err",   {31'd0, a_err},   {31'd0, e_err});
    if (e_ack) pend = 1'b0;
    if (req && e_ready) begin
      pend    = 1'b1;
      ack_cyc = cyc + LAT + 1;
      p_we    = we;
      p_idx   = int'(addr[8:2]);
      p_wd    = wd;
      p_err   = mdl_bad(addr);
    end
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic do_reset();
    rst          = 1'b1;
    bus0.req_i   = 1'b0;
    bus1.req_i   = 1'b0;
    @(negedge clk);
    chk("rst_ready",  {31'd0, bus0.ready_o}, 32'd0);
    chk("rst_ack",    {31'd0, bus0.ack_o},   32'd0);
    chk("rst_busy",   {31'd0, bus0.busy_o},  32'd0);
    chk("rst_err",    {31'd0, bus0.err_o},   32'd0);
    chk("rst_rdata",  bus0.rdata_o,          32'd0);
    chk("rst_l1_ready", {31'd0, bus1.ready_o}, 32'd0);
    chk("rst_l1_ack",   {31'd0, bus1.ack_o},   32'd0);
    pend = 1'b0;
    for (int i = 0; i < 128; i++) mdl_mem[i] = 32'd0;
    @(posedge clk);
    cyc++;
    #1;
    rst = 1'b0;
  endtask

  task automatic transact(input bit we, input logic [31:0] addr, input logic [31:0] wd,
                          output logic [31:0] rd, output bit er, output int lat);
    bit          ar, aa, ae, done;
    logic [31:0] ad;
    int          acc, c;
    acc = -1; rd = 32'd0; er = 1'b0; lat = -1; done = 1'b0;
    for (int k = 0; k < 20 && acc < 0; k++) begin
      c = cyc;
      cycle(1'b1, we, addr, wd, ar, aa, ad, ae);
      if (ar) acc = c;
    end
    for (int k = 0; k < 20 && acc >= 0 && !done; k++) begin
      c = cyc;
      cycle(1'b0, 1'b0, 32'd0, 32'd0, ar, aa, ad, ae);
      if (aa) begin
        done = 1'b1; rd = ad; er = ae; lat = c - acc;
      end
    end
    if (!done) begin
      n_vec++; n_err++;
      $display("FAIL transact_timeout: addr %h got no ack, required one within 20 cycles", addr);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          ar, aa, ae, er;
    logic [31:0] ad, rd, a;
    int          lat;

    bus0.req_i = 0; bus0.we_i = 0; bus0.addr_i = 0; bus0.wdata_i = 0;
    bus1.req_i = 0; bus1.we_i = 0; bus1.addr_i = 0; bus1.wdata_i = 0;
    pend = 1'b0;
    ack_cyc = 0;
    do_reset();

    //        req we addr       wdata         rdy ack rdata         err
    add_vec(1, 1, 32'h10, 32'hDEADBEEF, 1, 0, 32'h0,        0);
    add_vec(0, 0, 32'h0,  32'h0,        0, 0, 32'h0,        0);
    add_vec(0, 0, 32'h0,  32'h0,        0, 0, 32'h0,        0);
    add_vec(0, 0, 32'h0,  32'h0,        0, 0, 32'h0,        0);
    add_vec(0, 0, 32'h0,  32'h0,        1, 1, 32'h0,        0);
    add_vec(1, 0, 32'h10, 32'h0,        1, 0, 32'h0,        0);
    add_vec(0, 0, 32'h0,  32'h0,        0, 0, 32'h0,        0);
    add_vec(0, 0, 32'h0,  32'h0,        0, 0, 32'h0,        0);
    add_vec(0, 0, 32'h0,  32'h0,        0, 0, 32'h0,        0);
    add_vec(0, 0, 32'h0,  32'h0,        1, 1, 32'hDEADBEEF, 0);
    add_vec(1, 1, 32'h20, 32'h1,        1, 0, 32'h0,        0);
    add_vec(1, 1, 32'h20, 32'h1,        0, 0, 32'h0,        0);
    add_vec(1, 1, 32'h20, 32'h1,        0, 0, 32'h0,        0);
    add_vec(1, 1, 32'h20, 32'h1,        0, 0, 32'h0,        0);
    add_vec(1, 0, 32'h20, 32'h0,        1, 1, 32'h0,        0);
    add_vec(1, 0, 32'h20, 32'h0,        0, 0, 32'h0,        0);
    add_vec(1, 0, 32'h20, 32'h0,        0, 0, 32'h0,        0);
    add_vec(1, 0, 32'h20, 32'h0,        0, 0, 32'h0,        0);
    add_vec(0, 0, 32'h0,  32'h0,        1, 1, 32'h1,        0);
    add_vec(1, 0, 32'h10, 32'h0,        1, 0, 32'h0,        0);
    add_vec(1, 1, 32'h40, 32'h99,       0, 0, 32'h0,        0);
    add_vec(0, 0, 32'h0,  32'h0,        0, 0, 32'h0,        0);
    add_vec(0, 0, 32'h0,  32'h0,        0, 0, 32'h0,        0);
    add_vec(0, 0, 32'h0,  32'h0,        1, 1, 32'hDEADBEEF, 0);
    add_vec(1, 0, 32'h40, 32'h0,        1, 0, 32'h0,        0);
    add_vec(0, 0, 32'h0,  32'h0,        0, 0, 32'h0,        0);
    add_vec(0, 0, 32'h0,  32'h0,        0, 0, 32'h0,        0);
    add_vec(0, 0, 32'h0,  32'h0,        0, 0, 32'h0,        0);
    add_vec(0, 0, 32'h0,  32'h0,        1, 1, 32'h0,        0);

    foreach (tbl[i]) begin
      cycle(tbl[i].req, tbl[i].we, tbl[i].addr, tbl[i].wdata, ar, aa, ad, ae);
      chk("tbl_ready", {31'd0, ar}, {31'd0, tbl[i].ready});
      chk("tbl_ack",   {31'd0, aa}, {31'd0, tbl[i].ack});
      chk("tbl_rdata", ad,          tbl[i].rdata);
      chk("tbl_err",   {31'd0, ae}, {31'd0, tbl[i].err});
    end

    // Reset while a write sits in WAIT: it must never land or ack.
    cycle(1'b1, 1'b1, 32'h30, 32'h55, ar, aa, ad, ae);
    cycle(1'b0, 1'b0, 32'h0, 32'h0, ar, aa, ad, ae);
    do_reset();
    for (int k = 0; k < 6; k++) begin
      cycle(1'b0, 1'b0, 32'h0, 32'h0, ar, aa, ad, ae);
      chk("rst_no_ack", {31'd0, aa}, 32'd0);
      chk("rst_ready_after", {31'd0, ar}, 32'd1);
    end
    transact(1'b0, 32'h30, 32'h0, rd, er, lat);
    chk("rst_read30", rd, 32'h0);
    chk("rst_read30_lat", lat, LAT + 1);

    transact(1'b1, 32'h13, 32'h7, rd, er, lat);
`ifdef DMEM_RESP_ERR_EN
    chk("err_w13_err", {31'd0, er}, 32'd1);
    transact(1'b0, 32'h10, 32'h0, rd, er, lat);
    chk("err_r10_data", rd, 32'h0);
`else
    chk("noerr_w13_err", {31'd0, er}, 32'd0);
    transact(1'b0, 32'h10, 32'h0, rd, er, lat);
    chk("noerr_r10_data", rd, 32'h7);
`endif
    chk("r10_err", {31'd0, er}, 32'd0);
    chk("r10_lat", lat, LAT + 1);

    // LATENCY=1 instance: read 0x0 acks two edges after acceptance.
    bus1.req_i = 1'b1; bus1.we_i = 1'b0; bus1.addr_i = 32'h0; bus1.wdata_i = 32'h0;
    @(negedge clk);
    chk("l1_ready", {31'd0, bus1.ready_o}, 32'd1);
    @(posedge clk); cyc++; #1;
    bus1.req_i = 1'b0;
    @(negedge clk);
    chk("l1_ack_e1",  {31'd0, bus1.ack_o},  32'd0);
    chk("l1_busy_e1", {31'd0, bus1.busy_o}, 32'd1);
    @(posedge clk); cyc++; #1;
    @(negedge clk);
    chk("l1_ack_e2",   {31'd0, bus1.ack_o}, 32'd1);
    chk("l1_rdata_e2", bus1.rdata_o,        32'd0);
    chk("l1_err_e2",   {31'd0, bus1.err_o}, 32'd0);
    @(posedge clk); cyc++; #1;
    @(negedge clk);
    chk("l1_ack_e3", {31'd0, bus1.ack_o}, 32'd0);
    @(posedge clk); cyc++; #1;

    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 99) == 0) begin
        do_reset();
      end else begin
        a = 32'($urandom_range(0, 15)) << 2;
        case ($urandom_range(0, 9))
          0: a[1:0]  = 2'($urandom);
          1: a[31:9] = 23'($urandom);
          default: ;
        endcase
        cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, $urandom,
              ar, aa, ad, ae);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
